mem_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and drives the MEM-side inputs of MEM/WB (MEMwreg, MEMm2reg, MEMwn, MEMaluResult, MEMmemOut).
- Performs loads and stores on a multi-cycle req/ack data bus. Formats byte lanes: byte enables on stores, extraction and sign/zero extension on loads.
- Stalls the pipeline while an access is outstanding and flags misaligned accesses and bus timeouts.

---
 rtl/cpu_defs.sv | 23 ++
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_lane_fmt.sv | 59 +++++
 rtl/mem_access_stage.sv | 136 +++++++++++++
 tb/tb_mem_access_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the
// alignment rule used to decide whether an access may go onto the bus.
package cpu_defs;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // A reserved size is treated like a misaligned access: it never reaches the bus.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SZ_HALF) && addr_lo[0]) ||
             ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
             (size == SZ_RSVD);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data bus between the MEM stage (master) and the data memory (slave).
// req is held until the one-cycle ack; rdata is only meaningful with ack.
interface mem_access_stage_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      input  dbus_rdata, dbus_ack
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      output dbus_rdata, dbus_ack
   );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for both directions: store byte enables / lane
// replication, and load lane extraction with sign or zero extension.
module mem_lane_fmt
   import cpu_defs::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        lsign,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: enable the addressed lanes and replicate the data across them.
   always_comb begin
      be    = 4'b0000;
      wdata = store_data;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         SZ_HALF: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            wdata = store_data;
         end
         default: begin
            be    = 4'b0000;
            wdata = store_data;
         end
      endcase
   end

   // Load side: pick the addressed lane, then extend with its MSB or zeros.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: load_data = {{24{lsign & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{lsign & half_sel[15]}}, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on the req/ack data bus, stalls
// the pipeline while an access is outstanding, and reports misaligned
// accesses and bus timeouts. Non-memory instructions pass straight through.
module mem_access_stage
   import cpu_defs::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        EXwreg,
   input  logic        EXm2reg,
   input  logic        EXwmem,
   input  logic        EXrmem,
   input  logic [1:0]  EXsize,
   input  logic        EXlsign,
   input  logic [4:0]  EXwn,
   input  logic [31:0] EXaluResult,
   input  logic [31:0] EXstoreData,
   mem_access_stage_if.master dbus,
   output logic        stall,
   output logic        MEMwreg,
   output logic        MEMm2reg,
   output logic [4:0]  MEMwn,
   output logic [31:0] MEMaluResult,
   output logic [31:0] MEMmemOut,
   output logic        align_err,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q;
   logic               req_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        lbuf_q;
   logic               bus_err_q;
   logic               abort_q;

   logic               mem_op;
   logic               misalign;
   logic               start;
   logic [31:0]        lbuf_d;
   logic [3:0]         be_fmt;
   logic [31:0]        wdata_fmt;

   assign mem_op   = EXrmem | EXwmem;
   assign misalign = is_misaligned(EXsize, EXaluResult[1:0]);
   assign start    = (state_q == S_IDLE) && mem_op && !misalign;

   mem_lane_fmt u_fmt (
      .size       (EXsize),
      .addr_lo    (EXaluResult[1:0]),
      .lsign      (EXlsign),
      .store_data (EXstoreData),
      .rdata      (dbus.dbus_rdata),
      .be         (be_fmt),
      .wdata      (wdata_fmt),
      .load_data  (lbuf_d)
   );

   // Access FSM: launch on IDLE, wait for ack or timeout in BUSY, release in DONE.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         cnt_q     <= '0;
         lbuf_q    <= '0;
         bus_err_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         bus_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_BUSY;
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  abort_q <= 1'b0;
               end
            end
            S_BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               // An ack in the final timeout cycle still completes normally.
               if (dbus.dbus_ack) begin
                  lbuf_q  <= lbuf_d;
                  req_q   <= 1'b0;
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  lbuf_q    <= '0;
                  req_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  abort_q   <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               abort_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Bus drive: EX/MEM is frozen during the access, so these stay stable until ack.
   assign dbus.dbus_req   = req_q;
   assign dbus.dbus_we    = EXwmem;
   assign dbus.dbus_addr  = {EXaluResult[31:2], 2'b00};
   assign dbus.dbus_be    = be_fmt;
   assign dbus.dbus_wdata = wdata_fmt;

   // Pipeline-facing outputs; reset forces a quiet, non-stalling bubble.
   always_comb begin
      stall     = !clr && (start || (state_q == S_BUSY));
      align_err = !clr && (state_q == S_IDLE) && mem_op && misalign;
      MEMwreg   = 1'b0;
      MEMmemOut = '0;
      if (!clr) begin
         if (state_q == S_DONE) begin
            MEMwreg   = EXwreg & !abort_q;
            MEMmemOut = lbuf_q;
         end else if ((state_q == S_IDLE) && !mem_op) begin
            MEMwreg = EXwreg;
         end
      end
   end

   assign MEMm2reg     = EXm2reg;
   assign MEMwn        = EXwn;
   assign MEMaluResult = EXaluResult;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for the MEM stage. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_mem_access_stage;

   logic        clk;
   logic        clr;
   logic        EXwreg, EXm2reg, EXwmem, EXrmem, EXlsign;
   logic [1:0]  EXsize;
   logic [4:0]  EXwn;
   logic [31:0] EXaluResult, EXstoreData;
   logic        stall, MEMwreg, MEMm2reg, align_err, bus_err;
   logic [4:0]  MEMwn;
   logic [31:0] MEMaluResult, MEMmemOut;

   int n_vec = 0;
   int n_err = 0;

   mem_access_stage_if dbus_bus ();

   mem_access_stage #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clk          (clk),
      .clr          (clr),
      .EXwreg       (EXwreg),
      .EXm2reg      (EXm2reg),
      .EXwmem       (EXwmem),
      .EXrmem       (EXrmem),
      .EXsize       (EXsize),
      .EXlsign      (EXlsign),
      .EXwn         (EXwn),
      .EXaluResult  (EXaluResult),
      .EXstoreData  (EXstoreData),
      .dbus         (dbus_bus.master),
      .stall        (stall),
      .MEMwreg      (MEMwreg),
      .MEMm2reg     (MEMm2reg),
      .MEMwn        (MEMwn),
      .MEMaluResult (MEMaluResult),
      .MEMmemOut    (MEMmemOut),
      .align_err    (align_err),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic wreg, input logic m2reg, input logic wmem, input logic rmem,
                         input logic [1:0] size, input logic lsign, input logic [4:0] wn,
                         input logic [31:0] addr, input logic [31:0] sd);
      EXwreg = wreg; EXm2reg = m2reg; EXwmem = wmem; EXrmem = rmem;
      EXsize = size; EXlsign = lsign; EXwn = wn; EXaluResult = addr; EXstoreData = sd;
   endtask

   task automatic set_nop();
      set_ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 32'h0000_1234, 32'h0);
   endtask

   task automatic test_reset();
      clr = 1'b1;
      set_nop();
      dbus_bus.dbus_ack = 1'b0;
      dbus_bus.dbus_rdata = '0;
      @(negedge clk);
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
      n_vec++; if (MEMwreg !== 1'b0) begin n_err++; $display("FAIL rst_wreg: got %b want 0", MEMwreg); end
      n_vec++; if (MEMmemOut !== 32'h0) begin n_err++; $display("FAIL rst_memout: got %h want 0", MEMmemOut); end
      n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", dbus_bus.dbus_req); end
      n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_buserr: got %b want 0", bus_err); end
      tick();
      clr = 1'b0;
      // Start a word load, then reset in the middle of BUSY.
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd3, 32'h0000_0100, 32'h0);
      @(negedge clk);
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_start_stall: got %b want 1", stall); end
      tick();
      n_vec++; if (dbus_bus.dbus_req !== 1'b1) begin n_err++; $display("FAIL rst_busy_req: got %b want 1", dbus_bus.dbus_req); end
      #2 clr = 1'b1;
      #1;
      n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL rst_async_req: got %b want 0", dbus_bus.dbus_req); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_async_stall: got %b want 0", stall); end
      set_nop();
      dbus_bus.dbus_ack = 1'b1;   // late ack arriving during reset
      tick();
      dbus_bus.dbus_ack = 1'b0;
      clr = 1'b0;
      @(negedge clk);
      n_vec++; if (MEMwreg !== 1'b1) begin n_err++; $display("FAIL nop_wreg: got %b want 1", MEMwreg); end
      n_vec++; if (MEMaluResult !== 32'h0000_1234) begin n_err++; $display("FAIL nop_alu: got %h want 00001234", MEMaluResult); end
      n_vec++; if (MEMwn !== 5'd5) begin n_err++; $display("FAIL nop_wn: got %0d want 5", MEMwn); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nop_stall: got %b want 0", stall); end
      n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL nop_req: got %b want 0", dbus_bus.dbus_req); end
      $display("reset + nop: wreg=%b alu=%h stall=%b", MEMwreg, MEMaluResult, stall);
      tick();
   endtask

   task automatic test_signed_byte_load();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 5'd7, 32'h0000_0103, 32'h0);
      dbus_bus.dbus_rdata = 32'h80FF_1122;
      for (int c = 0; c <= 2; c++) begin
         dbus_bus.dbus_ack = (c == 1);
         @(negedge clk);
         n_vec++; if (stall !== (c <= 1)) begin n_err++; $display("FAIL lb_stall c%0d: got %b want %b", c, stall, (c <= 1)); end
         if (c == 0) begin
            n_vec++; if (dbus_bus.dbus_be !== 4'b1000) begin n_err++; $display("FAIL lb_be: got %b want 1000", dbus_bus.dbus_be); end
            n_vec++; if (dbus_bus.dbus_addr !== 32'h0000_0100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", dbus_bus.dbus_addr); end
            n_vec++; if (MEMwreg !== 1'b0) begin n_err++; $display("FAIL lb_idle_wreg: got %b want 0", MEMwreg); end
         end
         if (c == 1) begin
            n_vec++; if (dbus_bus.dbus_req !== 1'b1) begin n_err++; $display("FAIL lb_req: got %b want 1", dbus_bus.dbus_req); end
            n_vec++; if (dbus_bus.dbus_we !== 1'b0) begin n_err++; $display("FAIL lb_we: got %b want 0", dbus_bus.dbus_we); end
         end
         if (c == 2) begin
            n_vec++; if (MEMmemOut !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", MEMmemOut); end
            n_vec++; if (MEMwreg !== 1'b1) begin n_err++; $display("FAIL lb_wreg: got %b want 1", MEMwreg); end
            n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL lb_req_drop: got %b want 0", dbus_bus.dbus_req); end
            $display("lb  addr=00000103 rdata=80ff1122 memout=%h", MEMmemOut);
            set_nop();
         end
         tick();
      end
      dbus_bus.dbus_ack = 1'b0;
   endtask

   task automatic test_unsigned_half_load();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 5'd9, 32'h0000_0102, 32'h0);
      dbus_bus.dbus_rdata = 32'h9ABC_0000;
      for (int c = 0; c <= 4; c++) begin
         dbus_bus.dbus_ack = (c == 3);
         @(negedge clk);
         n_vec++; if (stall !== (c <= 3)) begin n_err++; $display("FAIL lhu_stall c%0d: got %b want %b", c, stall, (c <= 3)); end
         if (c == 0) begin
            n_vec++; if (dbus_bus.dbus_be !== 4'b1100) begin n_err++; $display("FAIL lhu_be: got %b want 1100", dbus_bus.dbus_be); end
         end
         if (c == 4) begin
            n_vec++; if (MEMmemOut !== 32'h0000_9ABC) begin n_err++; $display("FAIL lhu_data: got %h want 00009abc", MEMmemOut); end
            n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL lhu_buserr: got %b want 0", bus_err); end
            $display("lhu addr=00000102 rdata=9abc0000 memout=%h", MEMmemOut);
            set_nop();
         end
         tick();
      end
      dbus_bus.dbus_ack = 1'b0;
   endtask

   task automatic test_byte_store();
      set_ex(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0000_0201, 32'h0000_00A5);
      dbus_bus.dbus_rdata = 32'h0;
      for (int c = 0; c <= 3; c++) begin
         dbus_bus.dbus_ack = (c == 2);
         @(negedge clk);
         n_vec++; if (stall !== (c <= 2)) begin n_err++; $display("FAIL sb_stall c%0d: got %b want %b", c, stall, (c <= 2)); end
         if (c == 1 || c == 2) begin
            n_vec++; if (dbus_bus.dbus_req !== 1'b1) begin n_err++; $display("FAIL sb_req c%0d: got %b want 1", c, dbus_bus.dbus_req); end
            n_vec++; if (dbus_bus.dbus_we !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b want 1", dbus_bus.dbus_we); end
            n_vec++; if (dbus_bus.dbus_be !== 4'b0010) begin n_err++; $display("FAIL sb_be: got %b want 0010", dbus_bus.dbus_be); end
            n_vec++; if (dbus_bus.dbus_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", dbus_bus.dbus_wdata); end
            n_vec++; if (dbus_bus.dbus_addr !== 32'h0000_0200) begin n_err++; $display("FAIL sb_addr: got %h want 00000200", dbus_bus.dbus_addr); end
         end
         if (c == 3) begin
            n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL sb_req_drop: got %b want 0", dbus_bus.dbus_req); end
            $display("sb  addr=00000201 sd=000000a5 be=0010 wdata=a5a5a5a5");
            set_nop();
         end
         tick();
      end
      dbus_bus.dbus_ack = 1'b0;
   endtask

   task automatic test_store_priority();
      // rmem and wmem both set: handled as a word store.
      set_ex(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0000_0040, 32'hDEAD_BEEF);
      for (int c = 0; c <= 2; c++) begin
         dbus_bus.dbus_ack = (c == 1);
         @(negedge clk);
         if (c == 1) begin
            n_vec++; if (dbus_bus.dbus_we !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b want 1", dbus_bus.dbus_we); end
            n_vec++; if (dbus_bus.dbus_be !== 4'b1111) begin n_err++; $display("FAIL sw_be: got %b want 1111", dbus_bus.dbus_be); end
            n_vec++; if (dbus_bus.dbus_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_wdata: got %h want deadbeef", dbus_bus.dbus_wdata); end
         end
         if (c == 2) begin
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sw_done_stall: got %b want 0", stall); end
            $display("sw  addr=00000040 sd=deadbeef (rmem+wmem)");
            set_nop();
         end
         tick();
      end
      dbus_bus.dbus_ack = 1'b0;
   endtask

   task automatic test_misaligned();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd4, 32'h0000_0302, 32'h0);
      @(negedge clk);
      n_vec++; if (align_err !== 1'b1) begin n_err++; $display("FAIL mis_alignerr: got %b want 1", align_err); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b want 0", stall); end
      n_vec++; if (MEMwreg !== 1'b0) begin n_err++; $display("FAIL mis_wreg: got %b want 0", MEMwreg); end
      n_vec++; if (MEMmemOut !== 32'h0) begin n_err++; $display("FAIL mis_memout: got %h want 0", MEMmemOut); end
      $display("lw  addr=00000302 misaligned align_err=%b", align_err);
      tick();
      set_nop();
      @(negedge clk);
      n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", dbus_bus.dbus_req); end
      n_vec++; if (align_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", align_err); end
      tick();
   endtask

   task automatic test_timeout();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd6, 32'h0000_0400, 32'h0);
      dbus_bus.dbus_rdata = 32'hFFFF_FFFF;
      dbus_bus.dbus_ack = 1'b0;
      for (int c = 0; c <= 18; c++) begin
         @(negedge clk);
         if (c <= 17) begin
            n_vec++; if (stall !== (c <= 16)) begin n_err++; $display("FAIL to_stall c%0d: got %b want %b", c, stall, (c <= 16)); end
            n_vec++; if (bus_err !== (c == 17)) begin n_err++; $display("FAIL to_buserr c%0d: got %b want %b", c, bus_err, (c == 17)); end
         end
         if (c == 17) begin
            n_vec++; if (MEMwreg !== 1'b0) begin n_err++; $display("FAIL to_wreg: got %b want 0", MEMwreg); end
            n_vec++; if (MEMmemOut !== 32'h0) begin n_err++; $display("FAIL to_memout: got %h want 0", MEMmemOut); end
            n_vec++; if (dbus_bus.dbus_req !== 1'b0) begin n_err++; $display("FAIL to_req: got %b want 0", dbus_bus.dbus_req); end
            $display("lw  addr=00000400 no ack: bus_err=%b", bus_err);
            set_nop();
         end
         if (c == 18) begin
            n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_pulse: got %b want 0", bus_err); end
         end
         tick();
      end
   endtask

   task automatic test_timeout_ack_wins();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd6, 32'h0000_0400, 32'h0);
      dbus_bus.dbus_rdata = 32'h1357_2468;
      for (int c = 0; c <= 17; c++) begin
         dbus_bus.dbus_ack = (c == 16);
         @(negedge clk);
         if (c == 17) begin
            n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL ack16_buserr: got %b want 0", bus_err); end
            n_vec++; if (MEMmemOut !== 32'h1357_2468) begin n_err++; $display("FAIL ack16_data: got %h want 13572468", MEMmemOut); end
            n_vec++; if (MEMwreg !== 1'b1) begin n_err++; $display("FAIL ack16_wreg: got %b want 1", MEMwreg); end
            n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ack16_stall: got %b want 0", stall); end
            $display("lw  addr=00000400 ack@16 memout=%h bus_err=%b", MEMmemOut, bus_err);
            set_nop();
         end
         tick();
      end
      dbus_bus.dbus_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_signed_byte_load();
      test_unsigned_half_load();
      test_byte_store();
      test_store_priority();
      test_misaligned();
      test_timeout();
      test_timeout_ack_wins();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
